reorder_buffer: RTL and testbench

Circular reorder buffer that sequences in-order retirement into `regfile` and owns its rename/flush control. The dispatcher allocates tags here and the common data bus (CDB) writes results back here. The buffer drives `regfile`'s commit port (`rob_regfile_*`) and the speculative-state reset, and broadcasts a pipeline flush on branch misprediction. Tag 0 is reserved as "no producer", matching `regfile`'s cleared `reorder` value.

---
 rtl/reorder_buffer.sv | 116 +++++++++++
 tb/tb_reorder_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags to the dispatcher and takes CDB results.
// Retires in order into the regfile, and flushes the pipeline on a mispredicted commit.
module reorder_buffer #(
  parameter int ROB_WIDTH  = 4,
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  dispatcher_rob_en_in,
  input  logic [REG_WIDTH-1:0]  dispatcher_rob_rd_in,
  output logic [ROB_WIDTH-1:0]  rob_dispatcher_tag_out,
  output logic                  rob_dispatcher_full_out,
  input  logic [ROB_WIDTH-1:0]  dispatcher_rob_qs_in,
  input  logic [ROB_WIDTH-1:0]  dispatcher_rob_qt_in,
  output logic                  rob_dispatcher_qs_ready_out,
  output logic                  rob_dispatcher_qt_ready_out,
  output logic [DATA_WIDTH-1:0] rob_dispatcher_qs_value_out,
  output logic [DATA_WIDTH-1:0] rob_dispatcher_qt_value_out,
  input  logic                  cdb_rob_en_in,
  input  logic [ROB_WIDTH-1:0]  cdb_rob_tag_in,
  input  logic [DATA_WIDTH-1:0] cdb_rob_value_in,
  input  logic                  cdb_rob_mispredict_in,
  input  logic [DATA_WIDTH-1:0] cdb_rob_target_in,
  output logic                  rob_regfile_en_out,
  output logic [REG_WIDTH-1:0]  rob_regfile_d_out,
  output logic [DATA_WIDTH-1:0] rob_regfile_value_out,
  output logic [ROB_WIDTH-1:0]  rob_regfile_h_out,
  output logic                  rob_regfile_rst_out,
  output logic                  rob_flush_out,
  output logic [DATA_WIDTH-1:0] rob_flush_pc_out
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] MAX_TAG   = ROB_WIDTH'(DEPTH - 1);
  localparam logic [ROB_WIDTH-1:0] FIRST_TAG = ROB_WIDTH'(1);

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_ready;
  logic [DEPTH-1:0]      r_mispredict;
  logic [REG_WIDTH-1:0]  r_rd     [DEPTH];
  logic [DATA_WIDTH-1:0] r_value  [DEPTH];
  logic [DATA_WIDTH-1:0] r_target [DEPTH];
  logic [ROB_WIDTH-1:0]  r_head;
  logic [ROB_WIDTH-1:0]  r_tail;
  logic [ROB_WIDTH-1:0]  r_count;

  logic w_full, w_commit, w_flush, w_alloc, w_wb;
  logic w_qs_hit, w_qs_byp, w_qt_hit, w_qt_byp;

  // Tag 0 means "no producer", so pointers wrap from MAX_TAG back to 1.
  function automatic logic [ROB_WIDTH-1:0] f_incr(input logic [ROB_WIDTH-1:0] p);
    return (p == MAX_TAG) ? FIRST_TAG : p + FIRST_TAG;
  endfunction

  assign w_full   = (r_count == MAX_TAG);
  assign w_commit = rdy_in && !rst_in && r_valid[r_head] && r_ready[r_head];
  assign w_flush  = w_commit && r_mispredict[r_head];
  assign w_alloc  = rdy_in && dispatcher_rob_en_in && !w_full && !w_flush;
  assign w_wb     = rdy_in && cdb_rob_en_in && (cdb_rob_tag_in != '0) && r_valid[cdb_rob_tag_in];

  assign rob_dispatcher_tag_out  = r_tail;
  assign rob_dispatcher_full_out = w_full;

  assign rob_regfile_en_out    = w_commit;
  assign rob_regfile_d_out     = r_rd[r_head];
  assign rob_regfile_value_out = r_value[r_head];
  assign rob_regfile_h_out     = r_head;
  assign rob_regfile_rst_out   = w_flush;
  assign rob_flush_out         = w_flush;
  assign rob_flush_pc_out      = r_target[r_head];

  // Operand lookups see a same-cycle CDB result, but only for a live entry.
  assign w_qs_hit = (dispatcher_rob_qs_in != '0) && r_valid[dispatcher_rob_qs_in];
  assign w_qs_byp = cdb_rob_en_in && (cdb_rob_tag_in == dispatcher_rob_qs_in);
  assign w_qt_hit = (dispatcher_rob_qt_in != '0) && r_valid[dispatcher_rob_qt_in];
  assign w_qt_byp = cdb_rob_en_in && (cdb_rob_tag_in == dispatcher_rob_qt_in);

  assign rob_dispatcher_qs_ready_out = w_qs_hit && (w_qs_byp || r_ready[dispatcher_rob_qs_in]);
  assign rob_dispatcher_qt_ready_out = w_qt_hit && (w_qt_byp || r_ready[dispatcher_rob_qt_in]);
  assign rob_dispatcher_qs_value_out = w_qs_byp ? cdb_rob_value_in : r_value[dispatcher_rob_qs_in];
  assign rob_dispatcher_qt_value_out = w_qt_byp ? cdb_rob_value_in : r_value[dispatcher_rob_qt_in];

  // Entry state, pointers and occupancy; a mispredicted commit empties the buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in || w_flush) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= FIRST_TAG;
      r_tail  <= FIRST_TAG;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_wb) begin
        r_ready[cdb_rob_tag_in]      <= 1'b1;
        r_value[cdb_rob_tag_in]      <= cdb_rob_value_in;
        r_mispredict[cdb_rob_tag_in] <= cdb_rob_mispredict_in;
        r_target[cdb_rob_tag_in]     <= cdb_rob_target_in;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_rd[r_tail]    <= dispatcher_rob_rd_in;
        r_tail          <= f_incr(r_tail);
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= f_incr(r_head);
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + FIRST_TAG;
        2'b01:   r_count <= r_count - FIRST_TAG;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue model of in-flight entries is checked every cycle,
// with hand-computed literals pinning the key scenarios.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        dispatcher_rob_en_in;
  logic [4:0]  dispatcher_rob_rd_in;
  logic [3:0]  rob_dispatcher_tag_out;
  logic        rob_dispatcher_full_out;
  logic [3:0]  dispatcher_rob_qs_in, dispatcher_rob_qt_in;
  logic        rob_dispatcher_qs_ready_out, rob_dispatcher_qt_ready_out;
  logic [31:0] rob_dispatcher_qs_value_out, rob_dispatcher_qt_value_out;
  logic        cdb_rob_en_in;
  logic [3:0]  cdb_rob_tag_in;
  logic [31:0] cdb_rob_value_in;
  logic        cdb_rob_mispredict_in;
  logic [31:0] cdb_rob_target_in;
  logic        rob_regfile_en_out;
  logic [4:0]  rob_regfile_d_out;
  logic [31:0] rob_regfile_value_out;
  logic [3:0]  rob_regfile_h_out;
  logic        rob_regfile_rst_out, rob_flush_out;
  logic [31:0] rob_flush_pc_out;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dispatcher_rob_en_in(dispatcher_rob_en_in), .dispatcher_rob_rd_in(dispatcher_rob_rd_in),
    .rob_dispatcher_tag_out(rob_dispatcher_tag_out), .rob_dispatcher_full_out(rob_dispatcher_full_out),
    .dispatcher_rob_qs_in(dispatcher_rob_qs_in), .dispatcher_rob_qt_in(dispatcher_rob_qt_in),
    .rob_dispatcher_qs_ready_out(rob_dispatcher_qs_ready_out),
    .rob_dispatcher_qt_ready_out(rob_dispatcher_qt_ready_out),
    .rob_dispatcher_qs_value_out(rob_dispatcher_qs_value_out),
    .rob_dispatcher_qt_value_out(rob_dispatcher_qt_value_out),
    .cdb_rob_en_in(cdb_rob_en_in), .cdb_rob_tag_in(cdb_rob_tag_in),
    .cdb_rob_value_in(cdb_rob_value_in), .cdb_rob_mispredict_in(cdb_rob_mispredict_in),
    .cdb_rob_target_in(cdb_rob_target_in),
    .rob_regfile_en_out(rob_regfile_en_out), .rob_regfile_d_out(rob_regfile_d_out),
    .rob_regfile_value_out(rob_regfile_value_out), .rob_regfile_h_out(rob_regfile_h_out),
    .rob_regfile_rst_out(rob_regfile_rst_out), .rob_flush_out(rob_flush_out),
    .rob_flush_pc_out(rob_flush_pc_out)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    int          tag;
    int          rd;
    bit          rdy;
    logic [31:0] val;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  int   nxt = 1;
  bit   armed = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_lookup(input int t, output bit rdy, output logic [31:0] val);
    rdy = 1'b0;
    val = '0;
    if (t != 0) begin
      foreach (q[i]) begin
        if (q[i].tag == t) begin
          if (cdb_rob_en_in && int'(cdb_rob_tag_in) == t) begin
            rdy = 1'b1;
            val = cdb_rob_value_in;
          end else begin
            rdy = q[i].rdy;
            val = q[i].val;
          end
        end
      end
    end
  endfunction

  // Model update: the queue holds live entries oldest-first.
  bit m_full, m_com, m_fl;
  initial forever begin
    @(posedge clk_in);
    if (rst_in) begin
      q.delete();
      nxt = 1;
      armed = 1'b1;
    end else if (rdy_in) begin
      m_full = (q.size() == 15);
      m_com  = (q.size() > 0) && q[0].rdy;
      m_fl   = m_com && q[0].mis;
      if (m_fl) begin
        q.delete();
        nxt = 1;
      end else begin
        if (cdb_rob_en_in && cdb_rob_tag_in != 4'd0) begin
          foreach (q[i]) begin
            if (q[i].tag == int'(cdb_rob_tag_in)) begin
              ent_t e;
              e = q[i];
              e.rdy = 1'b1;
              e.val = cdb_rob_value_in;
              e.mis = cdb_rob_mispredict_in;
              e.tgt = cdb_rob_target_in;
              q[i] = e;
            end
          end
        end
        if (m_com) void'(q.pop_front());
        if (dispatcher_rob_en_in && !m_full) begin
          ent_t e;
          e.tag = nxt; e.rd = int'(dispatcher_rob_rd_in); e.rdy = 1'b0;
          e.val = '0; e.mis = 1'b0; e.tgt = '0;
          q.push_back(e);
          nxt = (nxt == 15) ? 1 : nxt + 1;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  bit          c_com, c_fl, l_rdy;
  logic [31:0] l_val;
  initial forever begin
    @(negedge clk_in);
    if (armed) begin
      c_com = !rst_in && rdy_in && (q.size() > 0) && q[0].rdy;
      c_fl  = c_com && q[0].mis;
      chk("tag_out", 32'(rob_dispatcher_tag_out), 32'(nxt));
      chk("full", 32'(rob_dispatcher_full_out), (q.size() == 15) ? 32'd1 : 32'd0);
      chk("commit_en", 32'(rob_regfile_en_out), 32'(c_com));
      chk("regfile_rst", 32'(rob_regfile_rst_out), 32'(c_fl));
      chk("flush", 32'(rob_flush_out), 32'(c_fl));
      if (c_com) begin
        chk("commit_d", 32'(rob_regfile_d_out), 32'(q[0].rd));
        chk("commit_value", rob_regfile_value_out, q[0].val);
        chk("commit_h", 32'(rob_regfile_h_out), 32'(q[0].tag));
      end
      if (c_fl) chk("flush_pc", rob_flush_pc_out, q[0].tgt);
      exp_lookup(int'(dispatcher_rob_qs_in), l_rdy, l_val);
      chk("qs_ready", 32'(rob_dispatcher_qs_ready_out), 32'(l_rdy));
      if (l_rdy) chk("qs_value", rob_dispatcher_qs_value_out, l_val);
      exp_lookup(int'(dispatcher_rob_qt_in), l_rdy, l_val);
      chk("qt_ready", 32'(rob_dispatcher_qt_ready_out), 32'(l_rdy));
      if (l_rdy) chk("qt_value", rob_dispatcher_qt_value_out, l_val);
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid;
    @(negedge clk_in);
    #1;
  endtask

  task automatic drive(input bit en, input int rd, input bit cen, input int ctag,
                       input logic [31:0] cval, input bit mis, input logic [31:0] tgt);
    dispatcher_rob_en_in  = en;
    dispatcher_rob_rd_in  = 5'(rd);
    cdb_rob_en_in         = cen;
    cdb_rob_tag_in        = 4'(ctag);
    cdb_rob_value_in      = cval;
    cdb_rob_mispredict_in = mis;
    cdb_rob_target_in     = tgt;
  endtask

  task automatic idle;
    drive(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    dispatcher_rob_qs_in = 4'd0; dispatcher_rob_qt_in = 4'd0;
    idle();
    tick(); tick();
    rst_in = 1'b0;
    mid();
    chk("rst_tag", 32'(rob_dispatcher_tag_out), 32'd1);
    chk("rst_full", 32'(rob_dispatcher_full_out), 32'd0);
    chk("rst_en", 32'(rob_regfile_en_out), 32'd0);
    chk("rst_flush", 32'(rob_flush_out), 32'd0);
    chk("rst_qs_ready", 32'(rob_dispatcher_qs_ready_out), 32'd0);
    tick();

    // In-order retirement with out-of-order writeback
    for (int i = 1; i <= 3; i++) begin drive(1'b1, i, 1'b0, 0, 32'h0, 1'b0, 32'h0); tick(); end
    drive(1'b0, 0, 1'b1, 0, 32'hDEAD, 1'b0, 32'h0);
    mid(); chk("alloc3_tag", 32'(rob_dispatcher_tag_out), 32'd4); tick();
    drive(1'b0, 0, 1'b1, 2, 32'hAA, 1'b0, 32'h0); tick();
    drive(1'b0, 0, 1'b1, 1, 32'h55, 1'b0, 32'h0);
    mid(); chk("no_early_commit", 32'(rob_regfile_en_out), 32'd0); tick();
    idle();
    mid();
    chk("c1_en", 32'(rob_regfile_en_out), 32'd1);
    chk("c1_d", 32'(rob_regfile_d_out), 32'd1);
    chk("c1_value", rob_regfile_value_out, 32'h55);
    chk("c1_h", 32'(rob_regfile_h_out), 32'd1);
    tick();
    mid();
    chk("c2_d", 32'(rob_regfile_d_out), 32'd2);
    chk("c2_value", rob_regfile_value_out, 32'hAA);
    chk("c2_h", 32'(rob_regfile_h_out), 32'd2);
    tick();
    mid(); chk("tag3_held", 32'(rob_regfile_en_out), 32'd0); tick();
    dispatcher_rob_qs_in = 4'd3;
    drive(1'b0, 0, 1'b1, 3, 32'h77, 1'b0, 32'h0);
    mid();
    chk("bypass_ready", 32'(rob_dispatcher_qs_ready_out), 32'd1);
    chk("bypass_value", rob_dispatcher_qs_value_out, 32'h77);
    chk("tag0_ready", 32'(rob_dispatcher_qt_ready_out), 32'd0);
    tick();
    idle(); dispatcher_rob_qs_in = 4'd0;
    mid(); chk("c3_h", 32'(rob_regfile_h_out), 32'd3); tick();

    // Fill to capacity from a fresh reset
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    for (int i = 0; i < 15; i++) begin drive(1'b1, i + 1, 1'b0, 0, 32'h0, 1'b0, 32'h0); tick(); end
    drive(1'b1, 20, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    mid();
    chk("fill_full", 32'(rob_dispatcher_full_out), 32'd1);
    chk("fill_tag_wrap", 32'(rob_dispatcher_tag_out), 32'd1);
    tick();
    drive(1'b0, 0, 1'b1, 1, 32'h11, 1'b0, 32'h0);
    mid(); chk("extra_alloc_ignored", 32'(rob_dispatcher_tag_out), 32'd1); tick();
    drive(1'b1, 21, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    mid();
    chk("full_commit_en", 32'(rob_regfile_en_out), 32'd1);
    chk("full_during_commit", 32'(rob_dispatcher_full_out), 32'd1);
    tick();
    drive(1'b1, 22, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    mid();
    chk("unfull", 32'(rob_dispatcher_full_out), 32'd0);
    chk("realloc_tag", 32'(rob_dispatcher_tag_out), 32'd1);
    tick();
    idle();
    mid(); chk("refull_tag", 32'(rob_dispatcher_tag_out), 32'd2); tick();

    // Misprediction flush
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin drive(1'b1, i + 10, 1'b0, 0, 32'h0, 1'b0, 32'h0); tick(); end
    for (int t = 1; t <= 3; t++) begin drive(1'b0, 0, 1'b1, t, 32'h100 + 32'(t), 1'b0, 32'h0); tick(); end
    drive(1'b0, 0, 1'b1, 4, 32'h104, 1'b1, 32'h1000); tick();
    drive(1'b1, 9, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    mid();
    chk("mis_en", 32'(rob_regfile_en_out), 32'd1);
    chk("mis_d", 32'(rob_regfile_d_out), 32'd14);
    chk("mis_rst", 32'(rob_regfile_rst_out), 32'd1);
    chk("mis_flush", 32'(rob_flush_out), 32'd1);
    chk("mis_pc", rob_flush_pc_out, 32'h1000);
    tick();
    drive(1'b0, 0, 1'b1, 5, 32'h55, 1'b0, 32'h0);
    dispatcher_rob_qs_in = 4'd5;
    mid();
    chk("post_flush_tag", 32'(rob_dispatcher_tag_out), 32'd1);
    chk("post_flush_full", 32'(rob_dispatcher_full_out), 32'd0);
    chk("flushed_lookup", 32'(rob_dispatcher_qs_ready_out), 32'd0);
    tick();
    idle(); dispatcher_rob_qs_in = 4'd0;
    mid(); chk("flushed_no_commit", 32'(rob_regfile_en_out), 32'd0); tick();

    // Global stall
    drive(1'b1, 7, 1'b0, 0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 0, 1'b1, 1, 32'h33, 1'b0, 32'h0); tick();
    rdy_in = 1'b0;
    drive(1'b1, 8, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("stall_en", 32'(rob_regfile_en_out), 32'd0);
      chk("stall_tag", 32'(rob_dispatcher_tag_out), 32'd2);
      tick();
    end
    rdy_in = 1'b1; idle();
    mid();
    chk("resume_en", 32'(rob_regfile_en_out), 32'd1);
    chk("resume_d", 32'(rob_regfile_d_out), 32'd7);
    chk("resume_value", rob_regfile_value_out, 32'h33);
    tick();

    // Reset with ready entries pending, also with rdy_in low
    for (int i = 0; i < 6; i++) begin drive(1'b1, i + 1, 1'b0, 0, 32'h0, 1'b0, 32'h0); tick(); end
    for (int t = 3; t <= 7; t++) begin drive(1'b0, 0, 1'b1, t, 32'h200 + 32'(t), 1'b0, 32'h0); tick(); end
    drive(1'b0, 0, 1'b1, 2, 32'h202, 1'b0, 32'h0); tick();
    idle(); rst_in = 1'b1; rdy_in = 1'b0;
    mid(); chk("rst_no_commit", 32'(rob_regfile_en_out), 32'd0); tick();
    rst_in = 1'b0; rdy_in = 1'b1; dispatcher_rob_qs_in = 4'd3;
    mid();
    chk("rst2_tag", 32'(rob_dispatcher_tag_out), 32'd1);
    chk("rst2_full", 32'(rob_dispatcher_full_out), 32'd0);
    chk("rst2_en", 32'(rob_regfile_en_out), 32'd0);
    chk("rst2_lookup", 32'(rob_dispatcher_qs_ready_out), 32'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
